fm_demod: RTL

Quadrature FM demodulator. It sits directly downstream of the two channel decimating FIR filters (real/I and imaginary/Q) and consumes their output FIFOs. For each I/Q pair it multiplies the current sample by the conjugate of the previous one, computes a fixed-point quantized arctangent using a sequential divider, and applies the demodulation gain. One signed audio-rate sample is written to the downstream FIFO per pair consumed.

---
 rtl/fm_demod.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fm_demod.sv
// fm_demod: quadrature FM demodulator.
//
// For each I/Q pair popped from the two FIR output FIFOs, the block forms
// cur * conj(prev) and computes a quantized arctangent of that product. The
// arctangent uses a 32-cycle restoring divider. The block then applies the
// demodulation gain and writes one signed sample to the downstream FIFO.
// Samples do not overlap: a new pair is read only after the previous
// result has been written.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   real_in      head of real (I) FIFO, first-word-fall-through
//   real_empty   real FIFO empty
//   real_rd_en   pop real FIFO (always together with imag_rd_en)
//   imag_in      head of imag (Q) FIFO, first-word-fall-through
//   imag_empty   imag FIFO empty
//   imag_rd_en   pop imag FIFO
//   demod_out    demodulated sample, held stable while waiting to write
//   demod_wr_en  write strobe to downstream FIFO
//   demod_full   downstream FIFO full, only looked at in WRITE
module fm_demod #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10,
    parameter int QUAD1      = 804,
    parameter int QUAD3      = 2412,
    parameter int GAIN       = 758
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] real_in,
    input  logic                  real_empty,
    output logic                  real_rd_en,
    input  logic [DATA_WIDTH-1:0] imag_in,
    input  logic                  imag_empty,
    output logic                  imag_rd_en,
    output logic [DATA_WIDTH-1:0] demod_out,
    output logic                  demod_wr_en,
    input  logic                  demod_full
);

    localparam int DW    = DATA_WIDTH;
    localparam int W2    = 2 * DATA_WIDTH;
    localparam int QUANT = 1 << BITS;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0]    DIV_LAST = CNT_W'(DW - 1);
    localparam logic signed [DW-1:0] QUAD1_C = DW'(QUAD1);
    localparam logic signed [DW-1:0] QUAD3_C = DW'(QUAD3);
    localparam logic signed [DW-1:0] GAIN_C  = DW'(GAIN);

    typedef enum logic [2:0] {
        ST_READ      = 3'd0,
        ST_MULT      = 3'd1,
        ST_DESCALE   = 3'd2,
        ST_DIV_SETUP = 3'd3,
        ST_DIV       = 3'd4,
        ST_ANGLE     = 3'd5,
        ST_GAIN      = 3'd6,
        ST_WRITE     = 3'd7
    } state_t;

    // Sign-extend a sample to product width.
    function automatic logic signed [W2-1:0] sext(input logic signed [DW-1:0] v);
        return {{DW{v[DW-1]}}, v};
    endfunction

    // Divide by QUANT, truncating toward zero (bias negatives before the shift).
    function automatic logic signed [W2-1:0] descale(input logic signed [W2-1:0] v);
        logic signed [W2-1:0] bias;
        bias = v[W2-1] ? W2'(QUANT - 1) : {W2{1'b0}};
        return (v + bias) >>> BITS;
    endfunction

    state_t state_q, state_d;

    logic signed [DW-1:0] cur_r_q, cur_r_d, cur_i_q, cur_i_d;
    logic signed [DW-1:0] prev_r_q, prev_r_d, prev_i_q, prev_i_d;
    logic signed [W2-1:0] pr_q, pr_d, pi_q, pi_d;
    logic signed [DW-1:0] x_q, x_d, y_q, y_d;
    logic                 num_neg_q, num_neg_d;
    logic [DW-1:0]        quo_q, quo_d, rem_q, rem_d, den_q, den_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic signed [DW-1:0] angle_q, angle_d;
    logic [DW-1:0]        demod_out_q, demod_out_d;

    logic both_ready;

    // A pair is only available when both FIFOs hold data.
    assign both_ready = ~real_empty & ~imag_empty;
    assign demod_out  = demod_out_q;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_READ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READ: begin
                if (both_ready) begin
                    state_d = ST_MULT;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_MULT:      state_d = ST_DESCALE;
            ST_DESCALE:   state_d = ST_DIV_SETUP;
            ST_DIV_SETUP: state_d = ST_DIV;
            ST_DIV: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = ST_ANGLE;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_ANGLE:     state_d = ST_GAIN;
            ST_GAIN:      state_d = ST_WRITE;
            ST_WRITE: begin
                if (!demod_full) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default:      state_d = ST_READ;
        endcase
    end

    // FIFO strobes; gated by reset so nothing is popped or written while held in reset.
    always_comb begin
        real_rd_en  = 1'b0;
        imag_rd_en  = 1'b0;
        demod_wr_en = 1'b0;
        case (state_q)
            ST_READ: begin
                if (reset && both_ready) begin
                    real_rd_en = 1'b1;
                    imag_rd_en = 1'b1;
                end else begin
                    real_rd_en = 1'b0;
                    imag_rd_en = 1'b0;
                end
            end
            ST_WRITE: begin
                if (reset && !demod_full) begin
                    demod_wr_en = 1'b1;
                end else begin
                    demod_wr_en = 1'b0;
                end
            end
            default: begin
                real_rd_en  = 1'b0;
                imag_rd_en  = 1'b0;
                demod_wr_en = 1'b0;
            end
        endcase
    end

    // Datapath: each state advances one step of the demodulation arithmetic.
    always_comb begin
        logic signed [W2-1:0] wide_a;
        logic signed [W2-1:0] wide_b;
        logic signed [DW-1:0] abs_y;
        logic signed [DW-1:0] num;
        logic signed [DW-1:0] den;
        logic [DW:0]          trial;
        logic [DW:0]          diff;
        logic signed [DW-1:0] q_s;
        logic signed [DW-1:0] a_s;

        wide_a = {W2{1'b0}};
        wide_b = {W2{1'b0}};
        abs_y  = {DW{1'b0}};
        num    = {DW{1'b0}};
        den    = {DW{1'b0}};
        trial  = {(DW+1){1'b0}};
        diff   = {(DW+1){1'b0}};
        q_s    = {DW{1'b0}};
        a_s    = {DW{1'b0}};

        cur_r_d     = cur_r_q;
        cur_i_d     = cur_i_q;
        prev_r_d    = prev_r_q;
        prev_i_d    = prev_i_q;
        pr_d        = pr_q;
        pi_d        = pi_q;
        x_d         = x_q;
        y_d         = y_q;
        num_neg_d   = num_neg_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        den_d       = den_q;
        cnt_d       = cnt_q;
        angle_d     = angle_q;
        demod_out_d = demod_out_q;

        case (state_q)
            ST_READ: begin
                if (both_ready) begin
                    cur_r_d = real_in;
                    cur_i_d = imag_in;
                end else begin
                    cur_r_d = cur_r_q;
                    cur_i_d = cur_i_q;
                end
            end
            ST_MULT: begin
                // cur * conj(prev), then cur becomes the reference for the next pair.
                pr_d     = sext(cur_r_q) * sext(prev_r_q) + sext(cur_i_q) * sext(prev_i_q);
                pi_d     = sext(cur_i_q) * sext(prev_r_q) - sext(cur_r_q) * sext(prev_i_q);
                prev_r_d = cur_r_q;
                prev_i_d = cur_i_q;
            end
            ST_DESCALE: begin
                wide_a = descale(pr_q);
                wide_b = descale(pi_q);
                x_d    = wide_a[DW-1:0];
                y_d    = wide_b[DW-1:0];
            end
            ST_DIV_SETUP: begin
                // The +1 on |y| keeps den >= 1, so the divider never sees zero.
                abs_y = (y_q[DW-1] ? -y_q : y_q) + DW'(1);
                if (!x_q[DW-1]) begin
                    num = (x_q - abs_y) <<< BITS;
                    den = x_q + abs_y;
                end else begin
                    num = (x_q + abs_y) <<< BITS;
                    den = abs_y - x_q;
                end
                num_neg_d = num[DW-1];
                quo_d     = num[DW-1] ? (~num + DW'(1)) : num;
                rem_d     = {DW{1'b0}};
                den_d     = den;
                cnt_d     = {CNT_W{1'b0}};
            end
            ST_DIV: begin
                // Restoring step: shift the next dividend bit into the remainder.
                trial = {rem_q, quo_q[DW-1]};
                if (trial >= {1'b0, den_q}) begin
                    diff  = trial - {1'b0, den_q};
                    rem_d = diff[DW-1:0];
                    quo_d = {quo_q[DW-2:0], 1'b1};
                end else begin
                    rem_d = trial[DW-1:0];
                    quo_d = {quo_q[DW-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
            ST_ANGLE: begin
                // Reapply num's sign to the magnitude quotient.
                q_s    = num_neg_q ? -$signed(quo_q) : $signed(quo_q);
                wide_a = descale(sext(QUAD1_C) * sext(q_s));
                a_s    = (x_q[DW-1] ? QUAD3_C : QUAD1_C) - wide_a[DW-1:0];
                angle_d = y_q[DW-1] ? -a_s : a_s;
            end
            ST_GAIN: begin
                wide_a      = descale(sext(GAIN_C) * sext(angle_q));
                demod_out_d = wide_a[DW-1:0];
            end
            ST_WRITE: begin
                demod_out_d = demod_out_q;
            end
            default: begin
                demod_out_d = demod_out_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_r_q     <= {DW{1'b0}};
            cur_i_q     <= {DW{1'b0}};
            prev_r_q    <= {DW{1'b0}};
            prev_i_q    <= {DW{1'b0}};
            pr_q        <= {W2{1'b0}};
            pi_q        <= {W2{1'b0}};
            x_q         <= {DW{1'b0}};
            y_q         <= {DW{1'b0}};
            num_neg_q   <= 1'b0;
            quo_q       <= {DW{1'b0}};
            rem_q       <= {DW{1'b0}};
            den_q       <= {DW{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            angle_q     <= {DW{1'b0}};
            demod_out_q <= {DW{1'b0}};
        end else begin
            cur_r_q     <= cur_r_d;
            cur_i_q     <= cur_i_d;
            prev_r_q    <= prev_r_d;
            prev_i_q    <= prev_i_d;
            pr_q        <= pr_d;
            pi_q        <= pi_d;
            x_q         <= x_d;
            y_q         <= y_d;
            num_neg_q   <= num_neg_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            den_q       <= den_d;
            cnt_q       <= cnt_d;
            angle_q     <= angle_d;
            demod_out_q <= demod_out_d;
        end
    end

endmodule
